// File: rtl/avs_frame_decimator_if.sv
// Word-stream input and decimated-frame output bundle for avs_frame_decimator.
interface avs_frame_decimator_if;
  logic        wordValid;
  logic [15:0] fullWord;
  logic        frameSync;
  logic [15:0] ch0Out;
  logic [15:0] ch1Out;
  logic [15:0] ch2Out;
  logic [15:0] ch3Out;
  logic        frameValid;
  logic        syncErr;

  modport master (
    output wordValid, fullWord, frameSync,
    input  ch0Out, ch1Out, ch2Out, ch3Out, frameValid, syncErr
  );

  modport slave (
    input  wordValid, fullWord, frameSync,
    output ch0Out, ch1Out, ch2Out, ch3Out, frameValid, syncErr
  );
endinterface

// File: rtl/avs_frame_decimator.sv
// AVS frame decimator: splits the round-robin 4-channel word stream into
// channels and averages each over 2^LOG2_DECIM frames (floor division).
module avs_frame_decimator #(
  parameter int LOG2_DECIM = 2
) (
  input logic                  clock,
  input logic                  reset,
  avs_frame_decimator_if.slave bus
);
  localparam int D  = 1 << LOG2_DECIM;
  localparam int AW = 16 + LOG2_DECIM;
  // Keep at least one bit so the counter exists structurally; with D=1 it stays 0.
  localparam int DW = (LOG2_DECIM == 0) ? 1 : LOG2_DECIM;
  localparam logic [DW-1:0] DEC_LAST = DW'(D - 1);

  typedef logic signed [AW-1:0] acc_t;

  acc_t          acc [4];
  acc_t          acc_next [4];
  logic [1:0]    ch_idx;
  logic [1:0]    ch_idx_next;
  logic [DW-1:0] dec_cnt;
  logic [DW-1:0] dec_cnt_next;
  logic          sync_err;
  logic          sync_err_next;
  logic [15:0]   ch_out [4];
  logic [15:0]   ch_out_next [4];
  logic          frame_valid;
  logic          frame_valid_next;

  logic [1:0]    eff_ch;
  logic          resync;
  logic          first_frame;
  logic          fire;
  acc_t          word_ext;
  acc_t          acc_sum;

  // Arithmetic shift floors toward -inf; the average always fits 16 bits.
  function automatic logic [15:0] avg(input acc_t sum);
    acc_t shifted;
    shifted = sum >>> LOG2_DECIM;
    return shifted[15:0];
  endfunction

  // Decode the incoming word: effective channel, resync and block boundary.
  always_comb begin
    eff_ch      = bus.frameSync ? 2'd0 : ch_idx;
    resync      = bus.wordValid & bus.frameSync & (ch_idx != 2'd0);
    first_frame = resync | (dec_cnt == '0);
    word_ext    = acc_t'($signed(bus.fullWord));
    acc_sum     = first_frame ? word_ext : (acc[eff_ch] + word_ext);
    fire        = bus.wordValid & (eff_ch == 2'd3) & (dec_cnt == DEC_LAST);
  end

  // Next-state for accumulators, counters, sticky error and output frame.
  always_comb begin
    acc_next         = acc;
    ch_idx_next      = ch_idx;
    dec_cnt_next     = dec_cnt;
    sync_err_next    = sync_err;
    ch_out_next      = ch_out;
    frame_valid_next = 1'b0;
    if (bus.wordValid) begin
      if (resync) begin
        sync_err_next = 1'b1;
        for (int k = 1; k < 4; k++) begin
          acc_next[k] = '0;
        end
      end else begin
        sync_err_next = sync_err;
      end
      acc_next[eff_ch] = acc_sum;
      ch_idx_next      = eff_ch + 2'd1;
      if (eff_ch == 2'd3) begin
        dec_cnt_next = (dec_cnt == DEC_LAST) ? '0 : (dec_cnt + DW'(1));
      end else if (resync) begin
        dec_cnt_next = '0;
      end else begin
        dec_cnt_next = dec_cnt;
      end
      if (fire) begin
        for (int k = 0; k < 3; k++) begin
          ch_out_next[k] = avg(acc[k]);
        end
        ch_out_next[3]   = avg(acc_sum);
        frame_valid_next = 1'b1;
      end else begin
        frame_valid_next = 1'b0;
      end
    end else begin
      frame_valid_next = 1'b0;
    end
  end

  // State register; synchronous reset discards any partial block.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        acc[k]    <= '0;
        ch_out[k] <= 16'd0;
      end
      ch_idx      <= 2'd0;
      dec_cnt     <= '0;
      sync_err    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      acc         <= acc_next;
      ch_out      <= ch_out_next;
      ch_idx      <= ch_idx_next;
      dec_cnt     <= dec_cnt_next;
      sync_err    <= sync_err_next;
      frame_valid <= frame_valid_next;
    end
  end

  assign bus.ch0Out     = ch_out[0];
  assign bus.ch1Out     = ch_out[1];
  assign bus.ch2Out     = ch_out[2];
  assign bus.ch3Out     = ch_out[3];
  assign bus.frameValid = frame_valid;
  assign bus.syncErr    = sync_err;
endmodule

// File: tb/tb_avs_frame_decimator.sv
// Scoreboard bench for avs_frame_decimator: one DUT with D=4, one with D=1.
module tb_avs_frame_decimator;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  avs_frame_decimator_if bus2 ();
  avs_frame_decimator_if bus0 ();

  avs_frame_decimator #(.LOG2_DECIM(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));
  avs_frame_decimator #(.LOG2_DECIM(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int ch [4];
    bit err;
    int due;
  } exp_t;

  exp_t q2 [$];
  exp_t q0 [$];

  // Reference model: index 0 -> D=4 device, index 1 -> D=1 device.
  int m_idx [2];
  int m_frm [2];
  int m_sum [2][4];
  bit m_err [2];
  int m_d   [2] = '{4, 1};

  function automatic int fdiv(int s, int dd);
    int q;
    q = s / dd;
    if ((s % dd) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_idx[d] = 0;
      m_frm[d] = 0;
      m_err[d] = 1'b0;
      for (int k = 0; k < 4; k++) m_sum[d][k] = 0;
    end
    q2.delete();
    q0.delete();
  endtask

  task automatic model_word(int d, bit s, int w);
    int   c;
    exp_t e;
    if (s && m_idx[d] != 0) begin
      m_err[d] = 1'b1;
      m_frm[d] = 0;
      for (int k = 0; k < 4; k++) m_sum[d][k] = 0;
    end
    c = s ? 0 : m_idx[d];
    m_sum[d][c] += w;
    m_idx[d] = (c + 1) % 4;
    if (c == 3) begin
      m_frm[d]++;
      if (m_frm[d] == m_d[d]) begin
        for (int k = 0; k < 4; k++) begin
          e.ch[k] = fdiv(m_sum[d][k], m_d[d]);
          m_sum[d][k] = 0;
        end
        e.err = m_err[d];
        e.due = cyc + 1;
        m_frm[d] = 0;
        if (d == 0) q2.push_back(e);
        else        q0.push_back(e);
      end
    end
  endtask

  // Drive one word, then idle >= 2 cycles with junk on frameSync/fullWord.
  task automatic send(int d, bit s, int w);
    int gap;
    @(posedge clock); #1;
    if (d == 0) begin
      bus2.wordValid = 1'b1; bus2.frameSync = s; bus2.fullWord = w[15:0];
    end else begin
      bus0.wordValid = 1'b1; bus0.frameSync = s; bus0.fullWord = w[15:0];
    end
    model_word(d, s, w);
    @(posedge clock); #1;
    bus2.wordValid = 1'b0; bus2.frameSync = 1'($urandom_range(0, 1)); bus2.fullWord = 16'($urandom);
    bus0.wordValid = 1'b0; bus0.frameSync = 1'($urandom_range(0, 1)); bus0.fullWord = 16'($urandom);
    gap = 1 + $urandom_range(0, 2);
    repeat (gap) @(posedge clock);
  endtask

  function automatic int rnd_word();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic check_pulse(int d);
    logic        fv;
    logic        se;
    logic [15:0] o [4];
    int          qs;
    exp_t        e;
    if (d == 0) begin
      fv = bus2.frameValid; se = bus2.syncErr; qs = q2.size();
      o[0] = bus2.ch0Out; o[1] = bus2.ch1Out; o[2] = bus2.ch2Out; o[3] = bus2.ch3Out;
    end else begin
      fv = bus0.frameValid; se = bus0.syncErr; qs = q0.size();
      o[0] = bus0.ch0Out; o[1] = bus0.ch1Out; o[2] = bus0.ch2Out; o[3] = bus0.ch3Out;
    end
    if (fv) begin
      if (qs == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_pulse dut%0d: frameValid=1 but none expected (cycle %0d)", d, cyc);
      end else begin
        if (d == 0) e = q2.pop_front();
        else        e = q0.pop_front();
        chk($sformatf("latency_dut%0d", d), cyc, e.due);
        for (int k = 0; k < 4; k++)
          chk($sformatf("ch%0dOut_dut%0d", k, d), int'($signed(o[k])), e.ch[k]);
        chk($sformatf("syncErr_dut%0d", d), int'(se), int'(e.err));
      end
    end else if (qs != 0) begin
      if (d == 0) e = q2[0];
      else        e = q0[0];
      if (e.due <= cyc) begin
        n_checks++; n_err++;
        $display("FAIL missing_pulse dut%0d: frameValid=0 but pulse due at cycle %0d", d, e.due);
        if (d == 0) void'(q2.pop_front());
        else        void'(q0.pop_front());
      end
    end
  endtask

  // Monitor: compare every presented frame against the scoreboard.
  always @(negedge clock) begin
    check_pulse(0);
    check_pulse(1);
  end

  task automatic check_zero(string tag);
    chk({tag, "_fv2"}, int'(bus2.frameValid), 0);
    chk({tag, "_ch0_2"}, int'(bus2.ch0Out), 0);
    chk({tag, "_ch1_2"}, int'(bus2.ch1Out), 0);
    chk({tag, "_ch2_2"}, int'(bus2.ch2Out), 0);
    chk({tag, "_ch3_2"}, int'(bus2.ch3Out), 0);
    chk({tag, "_err2"}, int'(bus2.syncErr), 0);
    chk({tag, "_ch0_0"}, int'(bus0.ch0Out), 0);
    chk({tag, "_err0"}, int'(bus0.syncErr), 0);
  endtask

  task automatic check_outs(string tag, int a, int b, int c, int d3);
    @(negedge clock);
    chk({tag, "_ch0"}, int'($signed(bus2.ch0Out)), a);
    chk({tag, "_ch1"}, int'($signed(bus2.ch1Out)), b);
    chk({tag, "_ch2"}, int'($signed(bus2.ch2Out)), c);
    chk({tag, "_ch3"}, int'($signed(bus2.ch3Out)), d3);
  endtask

  initial begin
    bus2.wordValid = 1'b0; bus2.frameSync = 1'b0; bus2.fullWord = 16'd0;
    bus0.wordValid = 1'b0; bus0.frameSync = 1'b0; bus0.fullWord = 16'd0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Test 1: constant extreme frames, sync on every ch0.
    for (int f = 0; f < 4; f++) begin
      send(0, 1'b1, 100); send(0, 1'b0, -100); send(0, 1'b0, 32767); send(0, 1'b0, -32768);
    end
    check_outs("t1", 100, -100, 32767, -32768);
    chk("t1_syncErr", int'(bus2.syncErr), 0);

    // Test 2: floor rounding of negative sums.
    for (int f = 0; f < 4; f++) begin
      send(0, f == 0, (f == 3) ? -2 : -1);
      send(0, 1'b0, (f == 3) ? 2 : 1);
      send(0, 1'b0, 0);
      send(0, 1'b0, 0);
    end
    check_outs("t2", -2, 1, 0, 0);

    // Test 3: 32 words, sync only on the first.
    for (int i = 0; i < 32; i++) send(0, i == 0, rnd_word());
    chk("t3_syncErr", int'(bus2.syncErr), 0);

    // Test 4: resync on the 7th word, then 15 more words.
    for (int i = 0; i < 6; i++) send(0, i == 0, rnd_word());
    send(0, 1'b1, rnd_word());
    for (int i = 0; i < 15; i++) send(0, 1'b0, rnd_word());
    @(negedge clock);
    chk("t4_syncErr_set", int'(bus2.syncErr), 1);
    for (int i = 0; i < 8; i++) send(0, i == 0, rnd_word());
    chk("t4_syncErr_sticky", int'(bus2.syncErr), 1);

    // Test 5: reset mid-block, then constant-5 frames.
    for (int i = 0; i < 7; i++) send(0, i == 0, rnd_word());
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("t5_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) send(0, (i % 4) == 0, 5);
    check_outs("t5", 5, 5, 5, 5);

    // Randomised D=4 traffic with occasional in-phase syncs and resyncs.
    for (int i = 0; i < 120; i++) send(0, $urandom_range(0, 9) == 0, rnd_word());

    // Test 6: D=1 pass-through.
    send(1, 1'b1, 1); send(1, 1'b0, 2); send(1, 1'b0, 3); send(1, 1'b0, 4);
    send(1, 1'b1, -5); send(1, 1'b0, 6); send(1, 1'b0, -7); send(1, 1'b0, 8);
    @(negedge clock);
    chk("t6_ch0", int'($signed(bus0.ch0Out)), -5);
    chk("t6_ch3", int'($signed(bus0.ch3Out)), 8);
    for (int i = 0; i < 40; i++) send(1, $urandom_range(0, 7) == 0, rnd_word());

    repeat (6) @(posedge clock);
    chk("drain_dut0", q2.size(), 0);
    chk("drain_dut1", q0.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
